conv_window_sequencer: RTL and testbench

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

---
 rtl/conv_window_sequencer.sv | 100 ++++++++++
 tb/tb_conv_window_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Walks a 5x5 window over every output position of a square image, handing each window
// to an external dot-product engine and writing the engine's result into a row-major buffer.
module conv_window_sequencer #(
  parameter int IMG_DIM = 10,
  parameter int FLT_DIM = 5,
  parameter int OUT_DIM = IMG_DIM - FLT_DIM + 1,
  localparam int CNT_W  = $clog2(OUT_DIM + 1),
  localparam int ADDR_W = $clog2(OUT_DIM * OUT_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  win_row,
  output logic [CNT_W-1:0]  win_col,
  output logic              mac_start,
  input  logic              mac_done,
  input  logic [31:0]       mac_result,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_win;

  assign last_win = (win_row == CNT_W'(OUT_DIM - 1)) && (win_col == CNT_W'(OUT_DIM - 1));

  // The address is a pure function of the window counters, so clearing them clears it too.
  assign out_addr = ADDR_W'(win_row) * ADDR_W'(OUT_DIM) + ADDR_W'(win_col);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ISSUE;
      S_ISSUE: state_next = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)         state_next = S_IDLE;
        else if (mac_done) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (abort)         state_next = S_IDLE;
        else if (last_win) state_next = S_DONE;
        else               state_next = S_ISSUE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Abort suppresses the strobes of the cycle it arrives in; done is never cancelled.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mac_start = (state == S_ISSUE) && !abort;
    out_we    = (state == S_WRITE) && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_row  <= '0;
      win_col  <= '0;
      out_data <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        win_row <= '0;
        win_col <= '0;
      end
      if (state == S_WAIT && mac_done && !abort) out_data <= mac_result;
      // Counters advance only after a committed write, keeping the window stable through WAIT.
      if (out_we) begin
        if (win_col < CNT_W'(OUT_DIM - 1)) begin
          win_col <= win_col + CNT_W'(1);
        end else begin
          win_col <= '0;
          win_row <= win_row + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomised bench for conv_window_sequencer: a latency-variable engine model plus an
// image-progress model that predicts every window issue, write and done pulse.
module tb_conv_window_sequencer;

  localparam int OUT_DIM = 6;
  localparam int N_WIN   = OUT_DIM * OUT_DIM;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        mac_start;
  logic        mac_done;
  logic [31:0] mac_result;
  logic        out_we;
  logic [5:0]  out_addr;
  logic [31:0] out_data;

  logic        eng_done;
  logic        spur_done;
  assign mac_done = eng_done | spur_done;

  conv_window_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .win_row    (win_row),
    .win_col    (win_col),
    .mac_start  (mac_start),
    .mac_done   (mac_done),
    .mac_result (mac_result),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  int          n_starts = 0;
  int          n_done   = 0;
  int          epoch    = 0;
  int          fixed_lat = 0;
  bit          fixed_val = 0;
  logic [31:0] last_val = 32'h0;

  int          exp_idx    = 0;
  int          seen_epoch = 0;
  int          t_first    = 0;
  int          cyc        = 0;
  bit          win_open   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: answers each mac_start after L cycles with one result, then drives junk.
  initial begin
    int lat;
    eng_done   = 1'b0;
    mac_result = 32'h0;
    forever begin
      @(negedge clk);
      if (mac_start === 1'b1 && rst === 1'b0) begin
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
        repeat (lat) @(posedge clk);
        #1;
        last_val   = fixed_val ? 32'h42C8_0000 : $urandom;
        mac_result = last_val;
        eng_done   = 1'b1;
        @(posedge clk);
        #1;
        eng_done   = 1'b0;
        mac_result = $urandom;
      end
    end
  end

  // Image-progress model: windows are issued in row-major order 0..35, each written once.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        exp_idx    = 0;
        win_open   = 0;
      end
      if (rst === 1'b0) begin
        if (busy !== 1'b1) check("idle_quiet", 32'({mac_start, out_we, done}), 32'd0);
        if (mac_start === 1'b1) begin
          n_starts++;
          check("single_issue", 32'(win_open), 32'd0);
          check("issue_row", 32'(win_row), 32'(exp_idx / OUT_DIM));
          check("issue_col", 32'(win_col), 32'(exp_idx % OUT_DIM));
          if (exp_idx == 0) t_first = cyc;
          win_open = 1;
        end else if (win_open) begin
          check("hold_row", 32'(win_row), 32'(exp_idx / OUT_DIM));
          check("hold_col", 32'(win_col), 32'(exp_idx % OUT_DIM));
        end
        if (out_we === 1'b1) begin
          n_writes++;
          check("write_in_window", 32'(win_open), 32'd1);
          check("write_addr", 32'(out_addr), 32'(exp_idx));
          check("write_data", out_data, last_val);
          if (fixed_val) check("write_data_100", out_data, 32'h42C8_0000);
          exp_idx++;
          win_open = 0;
        end
        if (done === 1'b1) begin
          n_done++;
          check("done_after_all", 32'(exp_idx), 32'(N_WIN));
          if (fixed_lat != 0) check("done_latency", 32'(cyc - t_first), 32'(N_WIN * (fixed_lat + 2)));
          exp_idx = 0;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_mac_start"}, 32'(mac_start), 32'd0);
    check({tag, "_out_we"},    32'(out_we),    32'd0);
    check({tag, "_win_row"},   32'(win_row),   32'd0);
    check({tag, "_win_col"},   32'(win_col),   32'd0);
    check({tag, "_out_addr"},  32'(out_addr),  32'd0);
    check({tag, "_out_data"},  out_data,       32'd0);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_window(input int row, input int col, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mac_start === 1'b1 && int'(win_row) == row && int'(win_col) == col) begin
        seen = 1;
        break;
      end
    end
    check("window_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_image(input bit hold);
    int w0, s0, d0;
    w0 = n_writes;
    s0 = n_starts;
    d0 = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("start_cycle_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 if (!hold) start = 1'b0;
    @(negedge clk);
    check("first_issue", 32'({busy, mac_start}), 32'd3);
    wait_done(2000);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("post_done_busy", 32'(busy), 32'd0);
    check("image_writes", 32'(n_writes - w0), 32'(N_WIN));
    check("image_issues", 32'(n_starts - s0), 32'(N_WIN));
    check("image_dones", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int w0, s0, d0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Constant-result image with L=3: every write is 100.0, done 180 cycles after first issue.
    fixed_lat = 3;
    fixed_val = 1;
    run_image(0);
    fixed_val = 0;

    // Single-cycle engine latency: three cycles per window.
    fixed_lat = 1;
    run_image(0);

    // Abort coinciding with the engine result of window 7 (row 1, col 1).
    fixed_lat = 3;
    w0 = n_writes;
    d0 = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_window(1, 1, 500);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    epoch++;
    @(negedge clk);
    check("abort_with_mac_done", 32'(mac_done), 32'd1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({busy, out_we, done}), 32'd0);
    check("abort_writes", 32'(n_writes - w0), 32'd7);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    repeat (6) @(posedge clk);
    fixed_lat = 0;
    run_image(0);

    // Start held high for a whole image, then a spurious engine pulse while idle.
    run_image(1);
    w0 = n_writes;
    s0 = n_starts;
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (10) @(negedge clk);
    check("spurious_no_issue", 32'(n_starts - s0), 32'd0);
    check("spurious_no_write", 32'(n_writes - w0), 32'd0);

    // Reset while waiting on window 20 (row 3, col 2).
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_window(3, 2, 2000);
    @(posedge clk); #1 rst = 1'b1;
    epoch++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (12) @(posedge clk);
    run_image(0);

    // Further images with latency re-drawn from 1..8 per window.
    run_image(0);
    run_image(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
